// File: rtl/debug_cmd_pkg.sv
// Shared types and entry packing helpers for the JTAG debug command path.
// An entry is laid out as {kind, ir, data}, with data in the low bits.
package debug_cmd_pkg;

  typedef enum logic {
    CMD_UDR = 1'b0,
    CMD_UIR = 1'b1
  } cmd_kind_e;

  // Upper bounds for the helper functions; the real widths are passed in
  // as arguments and always fit inside these.
  localparam int IR_MAX    = 8;
  localparam int SR_MAX    = 64;
  localparam int ENTRY_MAX = 1 + IR_MAX + SR_MAX;

  function automatic int entry_width(input int ir_w, input int sr_w);
    return 1 + ir_w + sr_w;
  endfunction

  function automatic logic [ENTRY_MAX-1:0] low_mask(input int w);
    return ~({ENTRY_MAX{1'b1}} << w);
  endfunction

  function automatic logic [ENTRY_MAX-1:0] pack_entry(input cmd_kind_e kind,
                                                      input logic [IR_MAX-1:0] ir,
                                                      input logic [SR_MAX-1:0] data,
                                                      input int ir_w,
                                                      input int sr_w);
    logic [ENTRY_MAX-1:0] e;
    e = ENTRY_MAX'(data) & low_mask(sr_w);
    e = e | ((ENTRY_MAX'(ir) & low_mask(ir_w)) << sr_w);
    e = e | (ENTRY_MAX'(kind) << (ir_w + sr_w));
    return e;
  endfunction

  function automatic cmd_kind_e unpack_kind(input logic [ENTRY_MAX-1:0] e,
                                            input int ir_w, input int sr_w);
    return cmd_kind_e'(|(e & (ENTRY_MAX'(1) << (ir_w + sr_w))));
  endfunction

  function automatic logic [IR_MAX-1:0] unpack_ir(input logic [ENTRY_MAX-1:0] e,
                                                  input int ir_w, input int sr_w);
    return IR_MAX'((e >> sr_w) & low_mask(ir_w));
  endfunction

  function automatic logic [SR_MAX-1:0] unpack_data(input logic [ENTRY_MAX-1:0] e,
                                                    input int sr_w);
    return SR_MAX'(e & low_mask(sr_w));
  endfunction

endpackage

// File: rtl/debug_cmd_fifo.sv
// Small synchronous FIFO for debug commands. Pointers carry one wrap bit so
// full and empty are distinguished without a counter. A push while full is
// accepted only if a pop happens in the same cycle.
module debug_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 41
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; contents are meaningless until the pointers cover them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/debug_cmd_sync.sv
// System-clock side of the JTAG debug slave: synchronises the TCK-domain
// update-DR/update-IR strobes, queues the resulting commands and decodes each
// popped command into one-cycle action pulses for the OCI blocks.
module debug_cmd_sync
  import debug_cmd_pkg::*;
#(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [IR_WIDTH-1:0]    ir_in,
  input  logic [SR_WIDTH-1:0]    sr,
  input  logic                   vs_udr,
  input  logic                   vs_uir,
  input  logic                   cmd_ready,
  input  logic                   clr_overflow,
  output logic                   cmd_valid,
  output logic                   cmd_kind,
  output logic [IR_WIDTH-1:0]    cmd_ir,
  output logic [SR_WIDTH-1:0]    cmd_data,
  output logic [SR_WIDTH-1:0]    jdo,
  output logic [2**IR_WIDTH-1:0] take_action,
  output logic [2**IR_WIDTH-1:0] take_no_action,
  output logic                   uir_taken,
  output logic                   overflow
);

  localparam int EW  = entry_width(IR_WIDTH, SR_WIDTH);
  localparam int NCH = 2**IR_WIDTH;
  localparam int WCW = $clog2(SYNC_STAGES + 2);
  localparam logic [WCW-1:0] WARM_DONE = WCW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
  logic                   udr_dly, uir_dly;
  logic [WCW-1:0]         warm_cnt;
  logic                   armed;
  logic                   udr_rise, uir_rise, uir_req;
  logic                   uir_pend, uir_pend_next;
  logic                   push, pop, full, empty, drop;
  cmd_kind_e              push_kind;
  logic [SR_WIDTH-1:0]    push_data;
  logic [EW-1:0]          fifo_wr, fifo_rd;
  logic [NCH-1:0]         ch_sel;

  // Strobe synchronisers plus one delay flop each for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync <= '0;
      uir_sync <= '0;
      udr_dly  <= 1'b0;
      uir_dly  <= 1'b0;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_dly  <= udr_sync[SYNC_STAGES-1];
      uir_dly  <= uir_sync[SYNC_STAGES-1];
    end
  end

  // Warm-up counter: hides the edge a strobe held high through reset would make.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    warm_cnt <= '0;
    else if (!armed) warm_cnt <= warm_cnt + 1'b1;
  end

  assign armed    = (warm_cnt == WARM_DONE);
  assign udr_rise = armed & udr_sync[SYNC_STAGES-1] & ~udr_dly;
  assign uir_rise = armed & uir_sync[SYNC_STAGES-1] & ~uir_dly;
  assign uir_req  = uir_rise | uir_pend;

  // Push arbitration: UDR wins a collision, UIR waits one cycle in uir_pend.
  always_comb begin
    push          = 1'b0;
    push_kind     = CMD_UDR;
    push_data     = '0;
    uir_pend_next = 1'b0;
    if (udr_rise) begin
      push          = 1'b1;
      push_data     = sr;
      uir_pend_next = uir_req;
    end else if (uir_req) begin
      push      = 1'b1;
      push_kind = CMD_UIR;
    end
  end

  // Deferred-UIR flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) uir_pend <= 1'b0;
    else          uir_pend <= uir_pend_next;
  end

  assign fifo_wr = EW'(pack_entry(push_kind, IR_MAX'(ir_in), SR_MAX'(push_data),
                                  IR_WIDTH, SR_WIDTH));

  debug_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data (fifo_wr),
    .rd_data (fifo_rd),
    .full    (full),
    .empty   (empty)
  );

  assign cmd_valid = ~empty;
  assign cmd_kind  = unpack_kind(ENTRY_MAX'(fifo_rd), IR_WIDTH, SR_WIDTH);
  assign cmd_ir    = IR_WIDTH'(unpack_ir(ENTRY_MAX'(fifo_rd), IR_WIDTH, SR_WIDTH));
  assign cmd_data  = SR_WIDTH'(unpack_data(ENTRY_MAX'(fifo_rd), SR_WIDTH));
  assign pop       = cmd_valid & cmd_ready;
  assign drop      = push & full & ~pop;
  assign ch_sel    = NCH'(1) << cmd_ir;

  // Sticky overflow; a drop in the same cycle beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  // Decode of the popped entry into jdo and one-cycle pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      uir_taken      <= 1'b0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      uir_taken      <= 1'b0;
      if (pop) begin
        if (cmd_kind == CMD_UDR) begin
          jdo <= cmd_data;
          if (cmd_data[SR_WIDTH-1]) take_action    <= ch_sel;
          else                      take_no_action <= ch_sel;
        end else begin
          uir_taken <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/debug_cmd_sync.md
# debug_cmd_sync

Parametrised system-clock-side command synchroniser for the CPU JTAG debug slave. It takes update-DR/update-IR strobes and the captured shift register from the TCK domain, brings them into `clk` through a configurable synchroniser chain, and queues them in a small FIFO. The consumer drains the FIFO with a ready/valid handshake. Each accepted command is decoded into a one-hot take-action or take-no-action pulse per IR code. It sits between the virtual-JTAG TCK logic and the CPU's OCI break, memory and trace-control blocks.

## Interface
- `SR_WIDTH`, 38: captured shift-register width; bit `SR_WIDTH-1` selects action vs no-action.
- `IR_WIDTH`, 2: instruction width; `2**IR_WIDTH` action channels.
- `SYNC_STAGES`, 2: synchroniser flops per strobe, ≥2.
- `FIFO_DEPTH`, 4: command queue entries, power of two, ≥2.

Ports:
- `clk` in 1: system clock; the only clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `ir_in` in `IR_WIDTH`: TCK-domain IR; stable while the strobes are high.
- `sr` in `SR_WIDTH`: TCK-domain shift register; stable while `vs_udr` is high.
- `vs_udr` in 1: asynchronous update-DR level.
- `vs_uir` in 1: asynchronous update-IR level.
- `cmd_ready` in 1: consumer accepts the head entry.
- `clr_overflow` in 1: clears `overflow`.
- `cmd_valid` out 1: FIFO non-empty.
- `cmd_kind` out 1: head kind; 0 = UDR, 1 = UIR.
- `cmd_ir` out `IR_WIDTH`: head IR.
- `cmd_data` out `SR_WIDTH`: head data; zero for UIR entries.
- `jdo` out `SR_WIDTH`: data of the last popped UDR entry.
- `take_action` out `2**IR_WIDTH`: one-hot pulse.
- `take_no_action` out `2**IR_WIDTH`: one-hot pulse.
- `uir_taken` out 1: pulse on a popped UIR entry.
- `overflow` out 1: sticky flag set when a command is dropped.

## Operation
- Each strobe passes through a `SYNC_STAGES` flop chain plus one delay flop. A rising edge is last-stage high and delay-flop low.
- Warm-up counter: edge detection is suppressed for `SYNC_STAGES+1` cycles after reset release. A strobe already high at reset release therefore produces no command.
- A UDR edge enqueues {0, `ir_in`, `sr`}, sampled on the push edge.
- A UIR edge enqueues {1, `ir_in`, 0}.
- If UDR and UIR edges occur in the same cycle, UDR is pushed first. UIR is held in a one-bit pending flag and pushed the next cycle. A new UIR edge while the flag is set is merged (dropped silently).
- Push while full with no pop in the same cycle: the entry is dropped and `overflow` is set. Push and pop in the same cycle while full: the push succeeds.
- Pop on `cmd_valid & cmd_ready`. `cmd_*` are don't-care while `cmd_valid`=0. There is no bypass: a push into an empty FIFO shows `cmd_valid` on the next cycle.
- Popped UDR entry:
  - `jdo` ← `cmd_data`.
  - If `cmd_data[SR_WIDTH-1]`=1, `take_action[cmd_ir]` pulses; otherwise `take_no_action[cmd_ir]` pulses.
- Popped UIR entry: `uir_taken` pulses; `jdo` is unchanged.
- `overflow`: set has priority over `clr_overflow` when both occur in the same cycle.
- Reset values (asynchronous):
  - FIFO empty; pointers 0.
  - `jdo`=0; all pulses 0; `overflow`=0.
  - Sync and delay flops 0; pending flag 0; warm-up counter restarts.
- Reset mid-operation discards all queued and pending commands.

## Timing
- Strobe sampled high at edge k → push at edge k+`SYNC_STAGES` → `cmd_valid`=1 after that edge. Latency is `SYNC_STAGES` cycles, plus 1 if UIR was deferred.
- Pop at edge p → `jdo` and the pulses are registered at edge p, high for exactly cycle p..p+1.
- Sustained throughput: one pop per cycle. Two strobes need ≥`SYNC_STAGES`+1 cycles of separation at the input to be distinguished.

## Structure
- `debug_cmd_pkg`:
  - `cmd_kind_e` (UDR=0, UIR=1).
  - Entry-width constant function `1+IR_WIDTH+SR_WIDTH`.
  - Pack/unpack functions for the entry.
- Sub-module `debug_cmd_fifo`: parametrised depth/width, full/empty, simultaneous push/pop; instantiated once.
- Synchronisers stay inline.

## Test plan
- Reset release with `vs_udr`=1 held → no `cmd_valid` within 10 cycles; `overflow`=0.
- `ir_in`=2, `sr`=38'h20_0000_00AB, `vs_udr` pulse, `cmd_ready`=1 → `cmd_valid` 2 cycles after sampling; next cycle `take_action`=4'b0100 for 1 cycle, `jdo`=38'h20_0000_00AB.
- Same with `sr[37]`=0, `ir_in`=1 → `take_no_action`=4'b0010; `take_action`=0.
- `vs_udr` and `vs_uir` rise together, `ir_in`=3 → two entries in order UDR then UIR, on consecutive cycles.
- `cmd_ready`=0, 5 UDR strobes, `FIFO_DEPTH`=4 → 4 entries held, `overflow`=1. Drain them in order. Then `clr_overflow` asserted together with a new overflow → `overflow` stays 1.
- Assert `reset_n`=0 with 3 entries queued → `cmd_valid`=0, `jdo`=0 immediately, without waiting for a clock edge.
